// File: rtl/exec_result_pipe_pkg.sv
// Shared widths and helpers for the execute-result pipeline.
// Optional forwarding lookup is enabled with EXEC_RESULT_PIPE_FWD_EN.
package exec_result_pipe_pkg;

   localparam int REG_SIZE  = 32;
   localparam int ADDR_SIZE = 32;
   localparam int DST_SIZE  = 5;

   // Packed payload layout, MSB first: {aluresult, zero, overflow, new_pc, dst}
   function automatic int payload_width(input int data_w, input int addr_w, input int dst_w);
      return data_w + 2 + addr_w + dst_w;
   endfunction

endpackage

// File: rtl/exec_result_stage.sv
// One pipeline slot: a valid bit plus payload register with load enable and clear.
// Payload only loads when a real result arrives, so bubbles and flushes never disturb it.
module exec_result_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic         d_valid,
   input  logic [W-1:0] d_payload,
   output logic         q_valid,
   output logic [W-1:0] q_payload
);

   logic         valid_reg;
   logic [W-1:0] payload_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg   <= 1'b0;
         payload_reg <= '0;
      end else begin
         if (clear)
            valid_reg <= 1'b0;
         else if (load)
            valid_reg <= d_valid;
         if (!clear && load && d_valid)
            payload_reg <= d_payload;
      end
   end

   assign q_valid   = valid_reg;
   assign q_payload = payload_reg;

endmodule

// File: rtl/exec_result_pipe.sv
// Elastic execute-to-memory result pipeline with flush and occupancy count.
// Define EXEC_RESULT_PIPE_FWD_EN to add the youngest-match forwarding lookup.
module exec_result_pipe
   import exec_result_pipe_pkg::*;
#(
   parameter int DEPTH  = 3,
   parameter int DATA_W = REG_SIZE,
   parameter int ADDR_W = ADDR_SIZE,
   parameter int DST_W  = DST_SIZE
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_aluresult,
   input  logic                       in_zero,
   input  logic                       in_overflow,
   input  logic [ADDR_W-1:0]          in_new_pc,
   input  logic [DST_W-1:0]           in_dst,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_aluresult,
   output logic                       out_zero,
   output logic                       out_overflow,
   output logic [ADDR_W-1:0]          out_new_pc,
   output logic [DST_W-1:0]           out_dst,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef EXEC_RESULT_PIPE_FWD_EN
   ,
   input  logic [DST_W-1:0]           fwd_rs,
   output logic                       fwd_hit,
   output logic [DATA_W-1:0]          fwd_data
`endif
);

   localparam int PW    = payload_width(DATA_W, ADDR_W, DST_W);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] ready;
   logic [PW-1:0]    payload [DEPTH];
   logic [PW-1:0]    in_payload;
   logic             accept;
   logic             emit;
   logic [OCC_W-1:0] occupancy_reg;

   assign in_payload = {in_aluresult, in_zero, in_overflow, in_new_pc, in_dst};
   assign in_ready   = ready[0] && !flush;
   assign accept     = in_valid && in_ready;
   assign emit       = valid[DEPTH-1] && out_ready && !flush;

   // Stage i can move iff some stage at or ahead of it is empty, or the sink drains;
   // written as a reduction so the ready chain has no combinational self-loop.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic          d_valid;
      logic [PW-1:0] d_payload;

      if (gi == 0) begin : g_head
         assign d_valid   = accept;
         assign d_payload = in_payload;
      end else begin : g_body
         assign d_valid   = valid[gi-1];
         assign d_payload = payload[gi-1];
      end

      assign ready[gi] = out_ready || !(&valid[DEPTH-1:gi]);

      exec_result_stage #(.W(PW)) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (ready[gi]),
         .clear     (flush),
         .d_valid   (d_valid),
         .d_payload (d_payload),
         .q_valid   (valid[gi]),
         .q_payload (payload[gi])
      );
   end

   // Tracks popcount(valid) incrementally: at most one enters and one leaves per edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         occupancy_reg <= '0;
      else if (flush)
         occupancy_reg <= '0;
      else
         occupancy_reg <= occupancy_reg + OCC_W'(accept) - OCC_W'(emit);
   end

   assign occupancy = occupancy_reg;
   assign out_valid = valid[DEPTH-1] && !flush;
   assign {out_aluresult, out_zero, out_overflow, out_new_pc, out_dst} = payload[DEPTH-1];

`ifdef EXEC_RESULT_PIPE_FWD_EN
   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (valid[i] && (fwd_rs != '0) && (payload[i][DST_W-1:0] == fwd_rs)) begin
            fwd_hit  = 1'b1;
            fwd_data = payload[i][PW-1 -: DATA_W];
         end
      end
   end
`endif

endmodule

// File: tb/tb_exec_result_pipe.sv
// Randomized scoreboard bench for exec_result_pipe against a queue-based model.
// Forwarding checks are active when EXEC_RESULT_PIPE_FWD_EN is defined.
module tb_exec_result_pipe;

   localparam int DEPTH  = 3;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DST_W  = 5;
   localparam int OCC_W  = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [DATA_W-1:0] alu;
      logic              zero;
      logic              ovf;
      logic [ADDR_W-1:0] pc;
      logic [DST_W-1:0]  dst;
   } res_t;

   typedef struct {
      res_t r;
      int   acc;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_aluresult = '0;
   logic              in_zero = 1'b0;
   logic              in_overflow = 1'b0;
   logic [ADDR_W-1:0] in_new_pc = '0;
   logic [DST_W-1:0]  in_dst = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_aluresult;
   logic              out_zero;
   logic              out_overflow;
   logic [ADDR_W-1:0] out_new_pc;
   logic [DST_W-1:0]  out_dst;
   logic              flush = 1'b0;
   logic [OCC_W-1:0]  occupancy;
`ifdef EXEC_RESULT_PIPE_FWD_EN
   logic [DST_W-1:0]  fwd_rs = '0;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
`endif

   exec_result_pipe #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DST_W(DST_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_aluresult  (in_aluresult),
      .in_zero       (in_zero),
      .in_overflow   (in_overflow),
      .in_new_pc     (in_new_pc),
      .in_dst        (in_dst),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_aluresult (out_aluresult),
      .out_zero      (out_zero),
      .out_overflow  (out_overflow),
      .out_new_pc    (out_new_pc),
      .out_dst       (out_dst),
      .flush         (flush),
      .occupancy     (occupancy)
`ifdef EXEC_RESULT_PIPE_FWD_EN
      ,
      .fwd_rs        (fwd_rs),
      .fwd_hit       (fwd_hit),
      .fwd_data      (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     n_emit = 0;
   bit     mon_en = 1'b0;
   entry_t exp_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic res_t cur_in();
      res_t r;
      r.alu  = in_aluresult;
      r.zero = in_zero;
      r.ovf  = in_overflow;
      r.pc   = in_new_pc;
      r.dst  = in_dst;
      return r;
   endfunction

   function automatic res_t cur_out();
      res_t r;
      r.alu  = out_aluresult;
      r.zero = out_zero;
      r.ovf  = out_overflow;
      r.pc   = out_new_pc;
      r.dst  = out_dst;
      return r;
   endfunction

   // Monitor / scoreboard: samples on the falling edge what the next rising edge will act on.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         int  sz;
         bit  exp_ov;
         sz = exp_q.size();
         check("occupancy", occupancy, sz);
         exp_ov = !flush && (sz > 0) && ((cyc - exp_q[0].acc) >= DEPTH);
         check("out_valid", out_valid, exp_ov);
         check("in_ready", in_ready, ((sz < DEPTH) || out_ready) && !flush);
`ifdef EXEC_RESULT_PIPE_FWD_EN
         begin
            bit                hit = 1'b0;
            logic [DATA_W-1:0] dat = '0;
            if (fwd_rs != '0) begin
               for (int k = sz - 1; k >= 0; k--) begin
                  if (exp_q[k].r.dst == fwd_rs) begin
                     hit = 1'b1;
                     dat = exp_q[k].r.alu;
                     break;
                  end
               end
            end
            check("fwd_hit", fwd_hit, hit);
            check("fwd_data", fwd_data, dat);
         end
`endif
         if (flush) begin
            $display("flush: %0d in flight discarded", sz);
            exp_q.delete();
         end else begin
            if (out_valid && out_ready && sz > 0) begin
               entry_t e;
               e = exp_q.pop_front();
               n_emit++;
               $display("emit #%0d: alu=%h pc=%h dst=%0d z=%0b v=%0b", n_emit,
                        out_aluresult, out_new_pc, out_dst, out_zero, out_overflow);
               check("out_data", cur_out(), e.r);
            end
            if (in_valid && in_ready) begin
               entry_t e;
               e.r   = cur_in();
               e.acc = cyc;
               exp_q.push_back(e);
            end
         end
         cyc++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input logic [DATA_W-1:0] alu, input logic [DST_W-1:0] dst);
      in_aluresult = alu;
      in_dst       = dst;
      in_zero      = (alu == '0);
      in_overflow  = alu[31];
      in_new_pc    = ADDR_W'($urandom);
   endtask

   // Holds in_valid until accepted, bounded by a cycle budget.
   task automatic push(input logic [DATA_W-1:0] alu, input logic [DST_W-1:0] dst);
      bit ok = 1'b0;
      set_fields(alu, dst);
      in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL push_timeout: actual=in_ready stuck 0 required=accept within 50 cycles");
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic check_reset_outputs();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_occupancy", occupancy, 0);
      check("rst_in_ready", in_ready, !flush);
      check("rst_out_data", cur_out(), '0);
   endtask

   // Async reset pulse placed between clock edges (called at posedge+1).
   task automatic pulse_reset();
      #1 rst_n = 1'b0;
      #1 check_reset_outputs();
      exp_q.delete();
      $display("reset pulse");
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs();
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
      step();

      // Consecutive pushes with the sink always ready
      push(32'h11, 5'd1);
      push(32'h22, 5'd2);
      push(32'h33, 5'd3);
      idle(5);

      // Back-pressure: fourth push waits until the sink releases
      out_ready = 1'b0;
      push(32'h44, 5'd4);
      push(32'h55, 5'd5);
      push(32'h66, 5'd6);
      fork
         push(32'h77, 5'd7);
         begin
            repeat (3) step();
            out_ready = 1'b1;
         end
      join
      idle(6);

      // Bubble compaction under back-pressure
      out_ready = 1'b0;
      push(32'hA0, 5'd8);
      idle(2);
      push(32'hB0, 5'd9);
      idle(3);
      out_ready = 1'b1;
      idle(5);

      // Flush while full with a valid input presented
      out_ready = 1'b0;
      push(32'hC1, 5'd5);
      push(32'hC2, 5'd5);
      push(32'hC3, 5'd6);
      set_fields(32'hDEAD, 5'd5);
      in_valid = 1'b1;
`ifdef EXEC_RESULT_PIPE_FWD_EN
      fwd_rs = 5'd5;
`endif
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(5);

`ifdef EXEC_RESULT_PIPE_FWD_EN
      // Two matches on dst=5: the younger one must be forwarded
      out_ready = 1'b0;
      push(32'hAA, 5'd5);
      push(32'hBB, 5'd5);
      idle(2);
      check("fwd_young_hit", fwd_hit, 1'b1);
      check("fwd_young_data", fwd_data, 32'hBB);
      fwd_rs = 5'd0;
      #1 check("fwd_rs0_hit", fwd_hit, 1'b0);
      out_ready = 1'b1;
      idle(4);
`endif

      // Reset mid-stream
      push(32'hE1, 5'd1);
      push(32'hE2, 5'd2);
      in_valid = 1'b0;
      pulse_reset();
      step();
      push(32'hF1, 5'd3);
      idle(5);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         set_fields(DATA_W'($urandom), DST_W'($urandom_range(0, 7)));
         if ((i % 64) < 20)
            out_ready = ($urandom_range(0, 3) == 0);
         else
            out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 39) == 0);
`ifdef EXEC_RESULT_PIPE_FWD_EN
         fwd_rs = DST_W'($urandom_range(0, 7));
`endif
         if ($urandom_range(0, 299) == 0) begin
            flush = 1'b0;
            pulse_reset();
         end
         step();
      end
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(DEPTH + 3);
      check("drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
